// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a word-wide data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted.
module lsu_mem_master #(
  parameter int unsigned MEM_BYTES   = 512,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        unsigned_q;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [4:0]  sh;
  logic [31:0] load_val;
  logic [31:0] mask;
  logic [31:0] merged;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign mem_we     = (state_q == WR);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign sh         = {addr_q[1:0], 3'b000};

  // alignment, size and range check on the incoming request
  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (CHECK_RANGE && (req_addr >= MEM_BYTES))
      req_err = 1'b1;
  end

  // lane extraction with extension, and lane merge for RMW
  always_comb begin
    load_val = mem_rd;
    mask     = 32'hffff_ffff;
    unique case (1'b1)
      size_q == 2'b00: begin
        load_val = unsigned_q
          ? {24'b0, mem_rd[sh +: 8]}
          : {{24{mem_rd[sh + 5'd7]}}, mem_rd[sh +: 8]};
        mask = 32'h0000_00ff << sh;
      end
      size_q == 2'b01: begin
        load_val = unsigned_q
          ? {16'b0, mem_rd[sh +: 16]}
          : {{16{mem_rd[sh + 5'd15]}}, mem_rd[sh +: 16]};
        mask = 32'h0000_ffff << sh;
      end
      default: begin
        load_val = mem_rd;
        mask     = 32'hffff_ffff;
      end
    endcase
    merged = (mem_rd & ~mask) | ((wdata_q << sh) & mask);
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)
            state_d = RESP;
          else if (req_we && (req_size == 2'b10))
            state_d = WR;
          else
            state_d = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = we_q ? WR : RESP;
      WR:         state_d = RESP;
      RESP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // state, request capture and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      mem_wd     <= '0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        we_q       <= req_we;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
        mem_wd     <= req_wdata;
      end
      if (state_q == RD_CAPTURE) begin
        if (we_q)
          mem_wd <= merged;
        else
          resp_rdata <= load_val;
      end
    end
  end

endmodule
